// File: rtl/ysyx_22041211_ifu_pkg.sv
// Shared constants for the NPC instruction fetch unit: FSM encoding,
// reset vector and instruction length.
package ysyx_22041211_ifu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } ifu_state_t;

   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
   localparam int          INST_LEN     = 4;

endpackage

// File: rtl/ysyx_22041211_Reg.sv
// Generic write-enabled register with asynchronous active-high reset.
module ysyx_22041211_Reg #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      dout <= RESET_VAL;
      else if (wen) dout <= din;
   end

endmodule

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: one outstanding imem read, valid/ready hand-off
// to decode, redirects from execute override every other event.
module ysyx_22041211_ifu
   import ysyx_22041211_ifu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data,
   input  logic              mem_resp_err,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              fetch_err,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
);

   ifu_state_t        state;
   logic              flush;
   logic [ADDR_W-1:0] pc;
   logic              pc_wen;
   logic [ADDR_W-1:0] pc_din;

   // pc moves only on redirect or when decode takes the held instruction
   assign pc_wen = redirect_valid || (state == HOLD && inst_ready);
   assign pc_din = redirect_valid ? redirect_pc : pc + ADDR_W'(INST_LEN);

   ysyx_22041211_Reg #(
      .WIDTH     (ADDR_W),
      .RESET_VAL (RESET_PC)
   ) u_pc (
      .clk  (clk),
      .rst  (rst),
      .wen  (pc_wen),
      .din  (pc_din),
      .dout (pc)
   );

   assign mem_req_valid = (state == REQ);
   assign mem_req_addr  = pc;
   assign inst_valid    = (state == HOLD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         flush     <= 1'b0;
         inst      <= '0;
         inst_pc   <= '0;
         fetch_err <= 1'b0;
      end else begin
         case (state)
            IDLE: if (!redirect_valid) state <= REQ;
            REQ: begin
               if (mem_req_ready) begin
                  state <= WAIT;
                  // request already left with the stale address
                  flush <= redirect_valid;
               end
            end
            WAIT: begin
               if (redirect_valid) begin
                  if (mem_resp_valid) begin
                     state <= REQ;
                     flush <= 1'b0;
                  end else begin
                     flush <= 1'b1;
                  end
               end else if (mem_resp_valid) begin
                  if (flush) begin
                     state <= REQ;
                     flush <= 1'b0;
                  end else begin
                     state     <= HOLD;
                     inst      <= mem_resp_data;
                     inst_pc   <= pc;
                     fetch_err <= mem_resp_err;
                  end
               end
            end
            HOLD: if (redirect_valid || inst_ready) state <= REQ;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Scoreboard bench for the fetch unit: stimulus queues expected requests and
// instructions, a negedge monitor pops them on each handshake.
module tb_ysyx_22041211_ifu;

   typedef struct packed {
      logic [31:0] d;
      logic [31:0] pc;
      logic        e;
   } inst_t;

   logic        clk = 0;
   logic        rst = 1;
   logic        mem_req_valid, mem_req_ready = 0;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid = 0;
   logic [31:0] mem_resp_data = 0;
   logic        mem_resp_err = 0;
   logic        inst_valid, inst_ready = 0;
   logic [31:0] inst, inst_pc;
   logic        fetch_err;
   logic        redirect_valid = 0;
   logic [31:0] redirect_pc = 0;

   int total = 0;
   int bad = 0;
   logic [31:0] exp_req[$];
   inst_t       exp_inst[$];

   ysyx_22041211_ifu dut (
      .clk(clk), .rst(rst),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .mem_resp_err(mem_resp_err),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .inst_pc(inst_pc), .fetch_err(fetch_err),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // monitor: compare every fired request and every accepted instruction
   always @(negedge clk) begin
      if (!rst && mem_req_valid && mem_req_ready) begin
         if (exp_req.size() == 0) chk("req_unexpected", {32'h0, mem_req_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
         else chk("req_addr_sb", {32'h0, mem_req_addr}, {32'h0, exp_req.pop_front()});
      end
      if (!rst && inst_valid && inst_ready && !redirect_valid) begin
         if (exp_inst.size() == 0) chk("inst_unexpected", {32'h0, inst}, 64'hFFFF_FFFF_FFFF_FFFF);
         else begin
            inst_t x;
            x = exp_inst.pop_front();
            chk("inst_sb", {32'h0, inst}, {32'h0, x.d});
            chk("inst_pc_sb", {32'h0, inst_pc}, {32'h0, x.pc});
            chk("fetch_err_sb", {63'h0, fetch_err}, {63'h0, x.e});
         end
      end
   end

   // one full fetch at address a; returns cycles from entry to inst_valid
   task automatic fetch_one(input logic [31:0] a, input logic [31:0] d, input logic e,
                            input int req_stall, input int hold_stall, output int lat);
      int n;
      n = 0;
      exp_req.push_back(a);
      mem_req_ready = 0;
      while (!mem_req_valid && n < 20) begin cyc(); n++; end
      chk("req_valid", {63'h0, mem_req_valid}, 64'h1);
      chk("req_addr", {32'h0, mem_req_addr}, {32'h0, a});
      repeat (req_stall) begin
         cyc(); n++;
         chk("req_stall_valid", {63'h0, mem_req_valid}, 64'h1);
         chk("req_stall_addr", {32'h0, mem_req_addr}, {32'h0, a});
      end
      mem_req_ready = 1; cyc(); n++; mem_req_ready = 0;
      chk("req_single", {63'h0, mem_req_valid}, 64'h0);
      mem_resp_valid = 1; mem_resp_data = d; mem_resp_err = e;
      cyc(); n++;
      mem_resp_valid = 0; mem_resp_data = 0; mem_resp_err = 0;
      chk("inst_valid", {63'h0, inst_valid}, 64'h1);
      exp_inst.push_back('{d, a, e});
      repeat (hold_stall) begin
         cyc();
         chk("hold_valid", {63'h0, inst_valid}, 64'h1);
         chk("hold_inst", {32'h0, inst}, {32'h0, d});
         chk("hold_pc", {32'h0, inst_pc}, {32'h0, a});
         chk("hold_noreq", {63'h0, mem_req_valid}, 64'h0);
         chk("hold_addr", {32'h0, mem_req_addr}, {32'h0, a});
      end
      inst_ready = 1; cyc(); inst_ready = 0;
      chk("next_req", {63'h0, mem_req_valid}, 64'h1);
      chk("next_addr", {32'h0, mem_req_addr}, {32'h0, a + 32'd4});
      lat = n;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      // reset state
      cyc(); cyc();
      chk("rst_req_valid", {63'h0, mem_req_valid}, 64'h0);
      chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
      chk("rst_inst", {32'h0, inst}, 64'h0);
      chk("rst_inst_pc", {32'h0, inst_pc}, 64'h0);
      chk("rst_err", {63'h0, fetch_err}, 64'h0);
      chk("rst_addr", {32'h0, mem_req_addr}, 64'h8000_0000);
      rst = 0;

      // best-case fetch, then held instruction, then request stall
      fetch_one(32'h8000_0000, 32'h0000_0413, 1'b0, 0, 0, lat);
      chk("first_latency", lat, 3);
      fetch_one(32'h8000_0004, 32'h0010_0093, 1'b0, 0, 5, lat);
      fetch_one(32'h8000_0008, 32'h0020_0113, 1'b0, 3, 0, lat);

      // redirect during WAIT: late response must be dropped
      exp_req.push_back(32'h8000_000C);
      mem_req_ready = 1; cyc(); mem_req_ready = 0;
      redirect_valid = 1; redirect_pc = 32'h8000_0100; cyc(); redirect_valid = 0;
      chk("wr_noinst0", {63'h0, inst_valid}, 64'h0);
      cyc();
      mem_resp_valid = 1; mem_resp_data = 32'hDEAD_BEEF; cyc(); mem_resp_valid = 0;
      chk("wr_noinst1", {63'h0, inst_valid}, 64'h0);
      chk("wr_req_valid", {63'h0, mem_req_valid}, 64'h1);
      chk("wr_req_addr", {32'h0, mem_req_addr}, 64'h8000_0100);
      fetch_one(32'h8000_0100, 32'h0030_0193, 1'b0, 0, 0, lat);

      // redirect in HOLD with inst_ready in the same cycle
      exp_req.push_back(32'h8000_0104);
      mem_req_ready = 1; cyc(); mem_req_ready = 0;
      mem_resp_valid = 1; mem_resp_data = 32'h0020_8113; cyc(); mem_resp_valid = 0;
      chk("hr_inst", {32'h0, inst}, 64'h0020_8113);
      chk("hr_inst_pc", {32'h0, inst_pc}, 64'h8000_0104);
      redirect_valid = 1; redirect_pc = 32'h8000_0200; inst_ready = 1; cyc();
      redirect_valid = 0; inst_ready = 0;
      chk("hr_req_valid", {63'h0, mem_req_valid}, 64'h1);
      chk("hr_req_addr", {32'h0, mem_req_addr}, 64'h8000_0200);

      // access fault delivered as data, fetching continues at pc+4
      fetch_one(32'h8000_0200, 32'h0, 1'b1, 0, 0, lat);

      // reset during WAIT, stray response afterwards
      exp_req.push_back(32'h8000_0204);
      mem_req_ready = 1; cyc(); mem_req_ready = 0;
      rst = 1; #2;
      chk("mrst_req_valid", {63'h0, mem_req_valid}, 64'h0);
      chk("mrst_inst_valid", {63'h0, inst_valid}, 64'h0);
      chk("mrst_err", {63'h0, fetch_err}, 64'h0);
      rst = 0;
      mem_resp_valid = 1; mem_resp_data = 32'h0000_0BAD; cyc(); mem_resp_valid = 0;
      chk("mrst_noinst", {63'h0, inst_valid}, 64'h0);
      chk("mrst_req", {63'h0, mem_req_valid}, 64'h1);
      chk("mrst_addr", {32'h0, mem_req_addr}, 64'h8000_0000);
      fetch_one(32'h8000_0000, 32'h0000_0013, 1'b0, 0, 0, lat);

      // redirect in REQ without handshake, then pc wrap
      redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; cyc(); redirect_valid = 0;
      chk("rq_req_valid", {63'h0, mem_req_valid}, 64'h1);
      chk("rq_req_addr", {32'h0, mem_req_addr}, 64'hFFFF_FFFC);
      fetch_one(32'hFFFF_FFFC, 32'h0000_0093, 1'b0, 1, 1, lat);

      // redirect in REQ with handshake: response for old address is flushed
      exp_req.push_back(32'h0000_0000);
      mem_req_ready = 1; redirect_valid = 1; redirect_pc = 32'h8000_0300; cyc();
      mem_req_ready = 0; redirect_valid = 0;
      chk("rh_wait", {63'h0, mem_req_valid}, 64'h0);
      mem_resp_valid = 1; mem_resp_data = 32'h1234_5678; cyc(); mem_resp_valid = 0;
      chk("rh_noinst", {63'h0, inst_valid}, 64'h0);
      chk("rh_req_addr", {32'h0, mem_req_addr}, 64'h8000_0300);
      fetch_one(32'h8000_0300, 32'h0040_0213, 1'b0, 0, 0, lat);

      cyc();
      chk("req_queue_empty", exp_req.size(), 0);
      chk("inst_queue_empty", exp_inst.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
